// File: rtl/pea_psum_collector.sv
// pea_psum_collector: accumulates PE-array partial sums over input-channel passes into a
// ping-pong psum buffer and drains finished tiles over a valid/ready stream.
module pea_psum_collector #(
    parameter int COL      = 8,
    parameter int TILE_LEN = 16,
    parameter int PSUM_W   = 24,
    parameter int IDX_W    = 4,
    parameter int PV_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [COL-1:0]        pvalid,
    input  logic [COL*PSUM_W-1:0] pdata,
    input  logic                  ic_done,
    input  logic                  oc_done,
    input  logic                  conv_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COL*PSUM_W-1:0] out_data,
    output logic [COL-1:0]        out_mask,
    output logic                  out_last,
    output logic                  out_conv_last,
    output logic                  busy,
    output logic                  err_ovf
);
    localparam int NW = IDX_W + 1;
    typedef enum logic [1:0] {EMPTY, ACC, FULL, DRAIN} bst_t;

    bst_t                  bst [2];
    bst_t                  bst_n [2];
    logic [2:0]            mk [PV_LAT];
    logic                  ic_d, oc_d, conv_d, pclose;
    logic                  acc, first, ov, db;
    logic [NW-1:0]         idx, n_ent, idx_w, cnt;
    logic [NW-1:0]         tag_n [2];
    logic [1:0]            tag_c;
    logic [IDX_W-1:0]      di, wi;
    logic [COL*PSUM_W-1:0] mem [2][TILE_LEN];
    logic [COL-1:0]        mmask [2][TILE_LEN];
    logic                  acc_ok, room, do_wr, tc, hs, last, idle, bad;

    assign {conv_d, oc_d, ic_d} = mk[PV_LAT-1];
    assign pclose = ic_d || oc_d;
    assign wi     = idx[IDX_W-1:0];
    assign acc_ok = bst[acc] == EMPTY || bst[acc] == ACC;
    assign room   = idx < NW'(TILE_LEN);
    assign do_wr  = |pvalid && acc_ok && room;
    assign idx_w  = do_wr ? idx + NW'(1) : idx;
    // a single-pass tile closes in the same cycle its entry count is latched
    assign cnt    = first ? idx_w : n_ent;
    assign tc     = oc_d && acc_ok && cnt != '0;
    assign hs     = ov && out_ready;
    assign last   = {1'b0, di} == tag_n[db] - NW'(1);
    assign idle   = !ov && bst[0] != DRAIN && bst[1] != DRAIN;
    assign bad    = (|pvalid && !(acc_ok && room)) || (do_wr && !first && idx >= n_ent);

    always_comb begin
        bst_n = bst;
        if (do_wr && bst[acc] == EMPTY) bst_n[acc] = ACC;
        if (oc_d && acc_ok) bst_n[acc] = tc ? FULL : EMPTY;
        if (hs && last) bst_n[db] = EMPTY;
        if (hs && last && bst[~db] == FULL) bst_n[~db] = DRAIN;
        if (idle && bst[0] == FULL) bst_n[0] = DRAIN;
        else if (idle && bst[1] == FULL) bst_n[1] = DRAIN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PV_LAT; i++) mk[i] <= '0;
            bst[0]   <= EMPTY;
            bst[1]   <= EMPTY;
            tag_n[0] <= '0;
            tag_n[1] <= '0;
            tag_c    <= '0;
            acc      <= 1'b0;
            first    <= 1'b1;
            idx      <= '0;
            n_ent    <= '0;
            ov       <= 1'b0;
            db       <= 1'b0;
            di       <= '0;
            err_ovf  <= 1'b0;
        end else begin
            mk[0] <= {conv_done, oc_done, ic_done};
            for (int i = 1; i < PV_LAT; i++) mk[i] <= mk[i-1];
            bst[0] <= bst_n[0];
            bst[1] <= bst_n[1];
            idx    <= pclose ? '0 : idx_w;
            first  <= oc_d ? 1'b1 : (ic_d ? 1'b0 : first);
            if (first && pclose) n_ent <= idx_w;
            if (tc) begin
                tag_n[acc] <= cnt;
                tag_c[acc] <= conv_d;
                acc        <= ~acc;
            end
            if (bad) err_ovf <= 1'b1;
            // the drain bank switches straight over when the other bank is waiting
            if (!ov && (bst[0] == DRAIN || bst[1] == DRAIN)) begin
                ov <= 1'b1;
                db <= bst[1] == DRAIN;
                di <= '0;
            end else if (hs) begin
                if (!last) di <= di + IDX_W'(1);
                else if (bst[~db] == FULL) begin
                    db <= ~db;
                    di <= '0;
                end else ov <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mmask[acc][wi] <= first ? pvalid : mmask[acc][wi] | pvalid;
            for (int l = 0; l < COL; l++)
                if (pvalid[l])
                    mem[acc][wi][l*PSUM_W +: PSUM_W] <= first ? pdata[l*PSUM_W +: PSUM_W]
                        : mem[acc][wi][l*PSUM_W +: PSUM_W] + pdata[l*PSUM_W +: PSUM_W];
        end
    end

    always_comb begin
        out_data = '0;
        for (int l = 0; l < COL; l++)
            if (out_mask[l]) out_data[l*PSUM_W +: PSUM_W] = mem[db][di][l*PSUM_W +: PSUM_W];
    end

    assign out_valid     = ov;
    assign out_mask      = ov ? mmask[db][di] : '0;
    assign out_last      = ov && last;
    assign out_conv_last = out_last && tag_c[db];
    assign busy          = bst[0] != EMPTY || bst[1] != EMPTY || ov;
endmodule

// File: tb/tb_pea_psum_collector.sv
// tb_pea_psum_collector: table-driven tile vectors plus hand-written ping-pong, overflow
// and reset sequences for the psum collector.
module tb_pea_psum_collector;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [7:0]   pvalid = '0;
    logic [191:0] pdata = '0;
    logic         ic_done = 1'b0, oc_done = 1'b0, conv_done = 1'b0;
    logic         out_valid, out_ready = 1'b1;
    logic [191:0] out_data;
    logic [7:0]   out_mask;
    logic         out_last, out_conv_last, busy, err_ovf;
    int           checks = 0, fails = 0;

    typedef struct {
        int         n;
        int         passes;
        logic [7:0] pv;
        int         lm;
        int         em;
        int         c;
        logic       conv;
        logic [7:0] exp_mask;
        int         exp_l0_e0;
        int         exp_l0_last;
    } vec_t;

    vec_t tv [4];

    pea_psum_collector dut (
        .clk(clk), .rstn(rstn), .pvalid(pvalid), .pdata(pdata),
        .ic_done(ic_done), .oc_done(oc_done), .conv_done(conv_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_last(out_last), .out_conv_last(out_conv_last),
        .busy(busy), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    function automatic vec_t mkv(input int n, input int passes, input logic [7:0] pv,
                                 input int lm, input int em, input int c, input logic conv);
        vec_t v;
        v.n = n; v.passes = passes; v.pv = pv; v.lm = lm; v.em = em; v.c = c; v.conv = conv;
        v.exp_mask = pv;
        v.exp_l0_e0 = pv[0] ? passes * (lm + c) : 0;
        v.exp_l0_last = pv[0] ? passes * (lm + em * (n - 1) + c) : 0;
        return v;
    endfunction

    function automatic logic [191:0] pass_data(input vec_t v, input int e);
        logic [191:0] d = '0;
        for (int l = 0; l < 8; l++)
            if (v.pv[l]) d[l*24 +: 24] = 24'(v.lm * (l + 1) + v.em * e + v.c);
        return d;
    endfunction

    function automatic logic [191:0] exp_data(input vec_t v, input int e);
        logic [191:0] d = '0;
        for (int l = 0; l < 8; l++)
            if (v.pv[l]) d[l*24 +: 24] = 24'(v.passes * (v.lm * (l + 1) + v.em * e + v.c));
        return d;
    endfunction

    // markers are driven one cycle ahead of the pass's final pvalid
    task automatic feed(input vec_t v);
        for (int p = 0; p < v.passes; p++)
            for (int k = 0; k <= v.n; k++) begin
                ic_done   = k == v.n - 1;
                oc_done   = k == v.n - 1 && p == v.passes - 1;
                conv_done = oc_done && v.conv;
                pvalid    = k >= 1 ? v.pv : '0;
                pdata     = k >= 1 ? pass_data(v, k - 1) : '0;
                step();
            end
        {ic_done, oc_done, conv_done} = '0;
        pvalid = '0;
        pdata  = '0;
    endtask

    task automatic drain_check(input vec_t v);
        int w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        for (int e = 0; e < v.n; e++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, exp_data(v, e));
            chk("drain_mask", out_mask, v.exp_mask);
            chk("drain_last", out_last, e == v.n - 1);
            chk("drain_conv_last", out_conv_last, e == v.n - 1 && v.conv);
            if (e == 0) chk("lane0_first", out_data[23:0], 24'(v.exp_l0_e0));
            if (e == v.n - 1) chk("lane0_last", out_data[23:0], 24'(v.exp_l0_last));
            step();
        end
    endtask

    initial begin
        vec_t va, vb, vx, vy, vz;
        tv[0] = '{16, 1, 8'hFF, 1, 0, 0, 1'b0, 8'hFF, 1, 1};
        tv[1] = '{16, 3, 8'hFF, 0, 0, 10, 1'b0, 8'hFF, 30, 30};
        tv[2] = '{5, 2, 8'h07, 1, 2, 0, 1'b0, 8'h07, 2, 18};
        tv[3] = '{3, 2, 8'hFF, 3, 100, 7, 1'b1, 8'hFF, 20, 420};

        step();
        step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_ovf, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_last", out_last, 1'b0);
        rstn = 1'b1;
        step();

        for (int t = 0; t < 4; t++) begin
            feed(tv[t]);
            drain_check(tv[t]);
            step();
            chk("row_idle_busy", busy, 1'b0);
            chk("row_err", err_ovf, 1'b0);
        end

        va = mkv(16, 1, 8'hFF, 1, 1, 1000, 1'b0);
        vb = mkv(16, 2, 8'hFF, 1, 1, 2000, 1'b0);
        fork
            begin
                feed(va);
                feed(vb);
            end
            begin
                int got = 0, cyc = 0, e;
                while (got < 32 && cyc < 600) begin
                    out_ready = (cyc % 2) == 0;
                    if (out_valid) begin
                        e = got % 16;
                        chk("pp_data", out_data, exp_data(got < 16 ? va : vb, e));
                        chk("pp_last", out_last, e == 15);
                        if (out_ready) got++;
                    end
                    step();
                    cyc++;
                end
                chk("pp_count", got, 32);
            end
        join
        out_ready = 1'b1;
        step();
        step();
        chk("pp_busy", busy, 1'b0);
        chk("pp_err", err_ovf, 1'b0);

        out_ready = 1'b0;
        vx = mkv(4, 1, 8'hFF, 1, 0, 100, 1'b0);
        vy = mkv(4, 1, 8'hFF, 1, 0, 200, 1'b0);
        vz = mkv(4, 1, 8'hFF, 1, 0, 300, 1'b0);
        feed(vx);
        feed(vy);
        chk("ovf_before", err_ovf, 1'b0);
        feed(vz);
        chk("ovf_set", err_ovf, 1'b1);
        out_ready = 1'b1;
        drain_check(vx);
        drain_check(vy);
        step();
        step();
        chk("ovf_busy", busy, 1'b0);
        chk("ovf_sticky", err_ovf, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        chk("ovf_rst_err", err_ovf, 1'b0);

        feed(mkv(17, 1, 8'hFF, 0, 1, 0, 1'b0));
        chk("idx_ovf", err_ovf, 1'b1);
        drain_check(mkv(16, 1, 8'hFF, 0, 1, 0, 1'b0));

        out_ready = 1'b0;
        feed(mkv(8, 1, 8'hFF, 1, 1, 5, 1'b1));
        begin
            int w = 0;
            while (!out_valid && w < 100) begin
                step();
                w++;
            end
        end
        chk("cv_valid", out_valid, 1'b1);
        chk("cv_conv_last_e0", out_conv_last, 1'b0);
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("cv_mid_valid", out_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_err", err_ovf, 1'b0);
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mr_after_valid", out_valid, 1'b0);
        chk("mr_after_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
